iir_coe_loader: RTL and testbench

- Transmit end of the IIR filter's serial coefficient port (`coe`/`coe_en`).
- Holds a 6-entry coefficient bank written by the host/control side. On `start` it emits one complete load frame, and the filter then commits all six coefficients atomically.
- Sits between the control register interface and the `iir` block; one loader per filter instance.

---
 rtl/iir_coe_pkg.sv | 32 +++
 rtl/iir_coe_bank.sv | 36 +++
 rtl/iir_coe_loader.sv | 129 ++++++++++++
 tb/tb_iir_coe_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/iir_coe_pkg.sv
// Shared types and constants for the IIR coefficient loader.
// Holds the coefficient width, the bank size, the reset coefficient set and the FSM states.
package iir_coe_pkg;

  localparam int unsigned CW   = 17;
  localparam int unsigned NCOE = 6;

  typedef logic signed [CW-1:0] coe_t;

  // Reset coefficient set, Q2.15. It must match the filter's own reset set.
  localparam coe_t COE_DEF_B0 = 17'sd32768;
  localparam coe_t COE_DEF_B1 = -17'sd58935;
  localparam coe_t COE_DEF_B2 = 17'sd30050;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StCoef,
    StGapw,
    StCommit,
    StDone
  } coe_state_e;

  function automatic coe_t coe_default(input int unsigned idx);
    case (idx)
      0, 3:    return COE_DEF_B0;
      1, 4:    return COE_DEF_B1;
      default: return COE_DEF_B2;
    endcase
  endfunction

endpackage

// File: rtl/iir_coe_bank.sv
// Coefficient bank register file, plus the snapshot register that feeds the frame being sent.
// A write and a snapshot in the same cycle put the pre-write value into the snapshot.
module iir_coe_bank
  import iir_coe_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [2:0]          i_wr_addr,
  input  logic signed [CW-1:0] i_wr_data,
  input  logic                i_snap_ld,
  output coe_t                o_snap [NCOE]
);

  coe_t r_bank [NCOE];
  coe_t r_snap [NCOE];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NCOE; i++) begin
        r_bank[i] <= coe_default(i);
        r_snap[i] <= coe_default(i);
      end
    end else begin
      if (i_wr_en && (i_wr_addr < 3'(NCOE))) begin
        r_bank[i_wr_addr] <= i_wr_data;
      end
      if (i_snap_ld) begin
        r_snap <= r_bank;
      end
    end
  end

  assign o_snap = r_snap;

endmodule

// File: rtl/iir_coe_loader.sv
// Sends the coefficient bank to the IIR filter as one atomic 7-beat frame on coe/coe_en.
// When IIR_COE_AUTOLOAD_EN is defined, one frame starts by itself on the first clock after reset.
module iir_coe_loader
  import iir_coe_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [2:0]           i_wr_addr,
  input  logic signed [CW-1:0] i_wr_data,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_wr_drop,
  output logic signed [CW-1:0] o_coe,
  output logic                 o_coe_en
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  coe_state_e      r_state, w_state_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [GW-1:0]   r_gap_cnt, w_gap_d;
  coe_t            r_coe, w_coe_d;
  logic            r_coe_en, r_busy, r_done, r_wr_drop;
  logic            w_go, w_snap_ld, w_wr_acc;
  coe_t            w_snap [NCOE];

`ifdef IIR_COE_AUTOLOAD_EN
  logic r_boot;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_boot <= 1'b1;
    else          r_boot <= 1'b0;
  end
  assign w_go = i_start | r_boot;
`else
  assign w_go = i_start;
`endif

  assign w_wr_acc = i_wr_en && (r_state == StIdle);

  iir_coe_bank u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_snap_ld (w_snap_ld),
    .o_snap    (w_snap)
  );

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_gap_d   = r_gap_cnt;
    w_snap_ld = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_go) begin
          w_state_d = StHdr;
          w_snap_ld = 1'b1;
        end
      end
      StHdr: begin
        w_idx_d   = '0;
        w_gap_d   = '0;
        w_state_d = (GAP > 0) ? StGapw : StCoef;
      end
      StCoef: begin
        if (r_idx == 3'(NCOE - 1)) begin
          w_state_d = StCommit;
        end else begin
          w_idx_d   = r_idx + 3'd1;
          w_state_d = (GAP > 0) ? StGapw : StCoef;
        end
      end
      StGapw: begin
        if (r_gap_cnt == GW'(GAP - 1)) begin
          w_gap_d   = '0;
          w_state_d = StCoef;
        end else begin
          w_gap_d = r_gap_cnt + 1'b1;
        end
      end
      StCommit: w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase

    // Outputs are registered from the next state; coe holds its last beat between beats.
    w_coe_d = r_coe;
    if (w_state_d == StHdr) begin
      w_coe_d = '0;
    end else if (w_state_d == StCoef) begin
      w_coe_d = w_snap[w_idx_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_gap_cnt <= '0;
      r_coe     <= '0;
      r_coe_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_gap_cnt <= w_gap_d;
      r_coe     <= w_coe_d;
      r_coe_en  <= (w_state_d == StHdr) || (w_state_d == StCoef);
      r_busy    <= (w_state_d != StIdle);
      r_done    <= (w_state_d == StDone);
      r_wr_drop <= i_wr_en && (r_state != StIdle);
    end
  end

  assign o_coe     = r_coe;
  assign o_coe_en  = r_coe_en;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_wr_drop = r_wr_drop;

endmodule

// File: tb/tb_iir_coe_loader.sv
// Directed bench for iir_coe_loader: one instance with back-to-back beats, one with GAP=2.
// Expected frames come from a bench-side copy of each bank, updated on every accepted write.
module tb_iir_coe_loader;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en0, wr_en2, start0, start2;
  logic [2:0]         wr_addr;
  logic signed [16:0] wr_data;

  logic               o0_busy, o0_done, o0_wr_drop, o0_coe_en;
  logic signed [16:0] o0_coe;
  logic               o2_busy, o2_done, o2_wr_drop, o2_coe_en;
  logic signed [16:0] o2_coe;

  logic signed [31:0] m0 [6];
  logic signed [31:0] m2 [6];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iir_coe_loader #(.GAP(0)) dut0 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (wr_en0),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_start   (start0),
    .o_busy    (o0_busy),
    .o_done    (o0_done),
    .o_wr_drop (o0_wr_drop),
    .o_coe     (o0_coe),
    .o_coe_en  (o0_coe_en)
  );

  iir_coe_loader #(.GAP(2)) dut2 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (wr_en2),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_start   (start2),
    .o_busy    (o2_busy),
    .o_done    (o2_done),
    .o_wr_drop (o2_wr_drop),
    .o_coe     (o2_coe),
    .o_coe_en  (o2_coe_en)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_defaults(input bit sel);
    logic signed [31:0] d [6];
    d = '{32768, -58935, 30050, 32768, -58935, 30050};
    if (sel) m2 = d;
    else     m0 = d;
  endtask

  task automatic do_write(input int addr, input int data);
    @(negedge clk);
    wr_en0  = 1'b1;
    wr_addr = 3'(addr);
    wr_data = 17'(data);
    @(negedge clk);
    wr_en0 = 1'b0;
    chk("wr_no_drop", o0_wr_drop, 0);
    if (addr < 6) m0[addr] = data;
  endtask

  // Call on the negedge where start was raised (or reset released for autoload).
  // Optionally injects a start (and a write) at cycle inj_k, both of which must be ignored.
  task automatic frame_check(input string tag, input bit sel, input int gap,
                             input int inj_k, input bit inj_wr);
    int                 len;
    int                 j;
    bit                 exp_en;
    logic signed [31:0] last;
    len  = 9 + 6 * gap;
    last = 0;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
      wr_en0 = 1'b0;
      wr_en2 = 1'b0;
      if (inj_k > 0 && k == inj_k + 1)
        chk({tag, ":wr_drop"}, sel ? o2_wr_drop : o0_wr_drop, 32'(inj_wr));
      exp_en = (k <= 7 + 6 * gap) && (((k - 1) % (gap + 1)) == 0);
      if (exp_en) begin
        j    = (k - 1) / (gap + 1);
        last = (j == 0) ? 0 : (sel ? m2[j-1] : m0[j-1]);
      end
      chk({tag, ":coe_en"}, sel ? o2_coe_en : o0_coe_en, 32'(exp_en));
      chk({tag, ":coe"},    sel ? o2_coe    : o0_coe,    last);
      chk({tag, ":done"},   sel ? o2_done   : o0_done,   32'(k == len));
      chk({tag, ":busy"},   sel ? o2_busy   : o0_busy,   32'(k <= len));
      if (k == inj_k) begin
        if (sel) start2 = 1'b1;
        else     start0 = 1'b1;
        if (inj_wr) begin
          if (sel) wr_en2 = 1'b1;
          else     wr_en0 = 1'b1;
          wr_addr = 3'd2;
          wr_data = 17'sd777;
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en0  = 1'b0;
    wr_en2  = 1'b0;
    start0  = 1'b0;
    start2  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    set_defaults(0);
    set_defaults(1);

    repeat (3) @(negedge clk);
    chk("rst:coe",     o0_coe, 0);
    chk("rst:coe_en",  o0_coe_en, 0);
    chk("rst:busy",    o0_busy, 0);
    chk("rst:done",    o0_done, 0);
    chk("rst:wr_drop", o0_wr_drop, 0);
    chk("rst:g2_en",   o2_coe_en, 0);
    chk("rst:g2_busy", o2_busy, 0);
    rst_n = 1'b1;

`ifdef IIR_COE_AUTOLOAD_EN
    frame_check("auto", 0, 0, 3, 0);
    repeat (14) @(negedge clk);
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_autoload", o0_coe_en, 0);
    end
`endif

    // Default bank, back-to-back beats.
    @(negedge clk);
    start0 = 1'b1;
    frame_check("dflt", 0, 0, 0, 0);

    // Reprogram; the write coinciding with start must not reach this frame.
    do_write(1, -60000);
    do_write(4, -50000);
    do_write(6, 999);
    @(negedge clk);
    wr_en0  = 1'b1;
    wr_addr = 3'd0;
    wr_data = 17'sd1234;
    start0  = 1'b1;
    frame_check("reprog", 0, 0, 0, 0);
    m0[0] = 1234;

    // Start and write during a frame are both ignored.
    @(negedge clk);
    start0 = 1'b1;
    frame_check("busy", 0, 0, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_restart", o0_coe_en, 0);
    end
    @(negedge clk);
    start0 = 1'b1;
    frame_check("readback", 0, 0, 0, 0);

    // GAP=2 instance: beats 3 cycles apart, done at start+21.
    @(negedge clk);
    start2 = 1'b1;
    frame_check("gap2", 1, 2, 0, 0);

    // Reset after beat 3: outputs clear asynchronously, bank reverts.
    @(negedge clk);
    start0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("pre_rst:coe_en", o0_coe_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst:coe",     o0_coe, 0);
    chk("arst:coe_en",  o0_coe_en, 0);
    chk("arst:busy",    o0_busy, 0);
    chk("arst:done",    o0_done, 0);
    chk("arst:wr_drop", o0_wr_drop, 0);
    set_defaults(0);
    set_defaults(1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("arst:no_done", o0_done, 0);
    end
    rst_n = 1'b1;
`ifndef IIR_COE_AUTOLOAD_EN
    start0 = 1'b1;
`endif
    frame_check("post_rst", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
